// File: rtl/obi_axil_fetch_bridge.sv
// OBI instruction-fetch to AXI-Lite-style read bridge: registered AR slot,
// registered in-order response path and a credit counter on outstanding reads.
module obi_axil_fetch_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic        err_o
);

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [AW-1:0]    WORD_MASK = ~AW'(32'h3);

    logic [AW-1:0]    araddr_q, araddr_d;
    logic             arvalid_q, arvalid_d;
    logic             rvalid_q, rvalid_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic slot_free_c;
    logic gnt_c;
    logic beat_ok_c;
    logic beat_bad_c;

    // Grant needs a free AR slot and a spare credit; gated off while in reset.
    always_comb begin
        slot_free_c = !arvalid_q || arready;
        gnt_c       = rst_n && instr_req_i && slot_free_c && (cnt_q < CNT_MAX);
        beat_ok_c   = rvalid && (cnt_q != '0);
        beat_bad_c  = rvalid && (cnt_q == '0);
    end

    always_comb begin
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        // AR slot: load on grant, retire on handshake, otherwise hold.
        if (gnt_c) begin
            araddr_d  = instr_addr_i & WORD_MASK;
            arvalid_d = 1'b1;
        end else if (arready) begin
            arvalid_d = 1'b0;
        end

        if (beat_ok_c) begin
            rvalid_d = 1'b1;
            rdata_d  = rdata;
        end

        if (beat_bad_c) begin
            err_d = 1'b1;
        end

        case ({gnt_c, beat_ok_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign instr_gnt_o    = gnt_c;
    assign araddr         = araddr_q;
    assign arvalid        = arvalid_q;
    assign instr_rvalid_o = rvalid_q;
    assign instr_rdata_o  = rdata_q;
    assign err_o          = err_q;
    assign rready         = 1'b1;

endmodule

// File: tb/tb_obi_axil_fetch_bridge.sv
// Bench for obi_axil_fetch_bridge: two instances (4 and 2 credits) on shared
// stimulus, a per-cycle reference model plus directed literal checks.
module tb_obi_axil_fetch_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;

    logic        gnt_a, rv_a, arvalid_a, rready_a, err_a;
    logic [31:0] rd_a, araddr_a;
    logic        gnt_b, rv_b, arvalid_b, rready_b, err_b;
    logic [31:0] rd_b, araddr_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    obi_axil_fetch_bridge #(.MAX_OUTSTANDING(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(req), .instr_gnt_o(gnt_a), .instr_addr_i(addr),
        .instr_rvalid_o(rv_a), .instr_rdata_o(rd_a),
        .araddr(araddr_a), .arvalid(arvalid_a), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready_a), .err_o(err_a)
    );

    obi_axil_fetch_bridge #(.MAX_OUTSTANDING(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(req), .instr_gnt_o(gnt_b), .instr_addr_i(addr),
        .instr_rvalid_o(rv_b), .instr_rdata_o(rd_b),
        .araddr(araddr_b), .arvalid(arvalid_b), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready_b), .err_o(err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Target: ROM contents, response latency and which instance's AR it serves.
    logic [31:0] rom [6] = '{32'h100002b7, 32'h0ff00313, 32'h0062a223,
                             32'h0042a383, 32'h0000006f, 32'h00000013};

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        int idx;
        idx = int'(a[31:2]);
        if (idx < 6) return rom[idx];
        return 32'hc0de_0000 | a;
    endfunction

    typedef struct {
        int          due;
        logic [31:0] d;
    } beat_t;

    beat_t       tq[$];
    int          cyc        = 0;
    int          tgt_lat    = 1;
    bit          tgt_sel    = 1'b0;
    bit          force_beat = 1'b0;
    logic [31:0] force_data = 32'h0;

    initial begin
        beat_t       b;
        logic        obs_v;
        logic [31:0] obs_a;
        rvalid = 1'b0;
        rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            rvalid = 1'b0;
            rdata  = 32'h5a5a_0000 | 32'(cyc & 16'hffff);
            if (!rst_n) tq.delete();
            if (force_beat) begin
                rvalid = 1'b1;
                rdata  = force_data;
            end else if (tq.size() > 0 && tq[0].due <= cyc) begin
                rvalid = 1'b1;
                rdata  = tq[0].d;
                void'(tq.pop_front());
            end
            obs_v = tgt_sel ? arvalid_b : arvalid_a;
            obs_a = tgt_sel ? araddr_b : araddr_a;
            if (rst_n && obs_v && arready) begin
                b.due = cyc + tgt_lat;
                b.d   = rom_word(obs_a);
                tq.push_back(b);
            end
        end
    end

    // Reference model: pending AR word, count of unanswered grants, last response.
    int          m_max [2] = '{4, 2};
    bit          m_pend[2];
    logic [31:0] m_addr[2];
    int          m_out [2];
    bit          m_rv  [2];
    logic [31:0] m_rd  [2];
    bit          m_err [2];

    task automatic model_reset(input int i);
        m_pend[i] = 1'b0;
        m_addr[i] = 32'h0;
        m_out[i]  = 0;
        m_rv[i]   = 1'b0;
        m_rd[i]   = 32'h0;
        m_err[i]  = 1'b0;
    endtask

    function automatic bit model_gnt(input int i);
        return rst_n && req && (!m_pend[i] || arready) && (m_out[i] < m_max[i]);
    endfunction

    task automatic model_step(input int i);
        bit g;
        bit acc;
        g   = model_gnt(i);
        acc = rvalid && (m_out[i] > 0);
        if (rvalid && m_out[i] == 0) m_err[i] = 1'b1;
        m_rv[i] = acc;
        if (acc) m_rd[i] = rdata;
        m_out[i] = m_out[i] + (g ? 1 : 0) - (acc ? 1 : 0);
        if (g) begin
            m_pend[i] = 1'b1;
            m_addr[i] = {addr[31:2], 2'b00};
        end else if (arready) begin
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_cmp(input int i, input string p, input logic g, input logic av,
                             input logic [31:0] aa, input logic rv, input logic [31:0] rd,
                             input logic e, input logic rr);
        chk({p, "gnt"},     32'(g),  32'(model_gnt(i)));
        chk({p, "arvalid"}, 32'(av), 32'(m_pend[i]));
        chk({p, "araddr"},  aa,      m_addr[i]);
        chk({p, "rvalid"},  32'(rv), 32'(m_rv[i]));
        chk({p, "rdata"},   rd,      m_rd[i]);
        chk({p, "err"},     32'(e),  32'(m_err[i]));
        chk({p, "rready"},  32'(rr), 32'h1);
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                model_reset(0);
                model_reset(1);
            end
            model_cmp(0, "mdl.a.", gnt_a, arvalid_a, araddr_a, rv_a, rd_a, err_a, rready_a);
            model_cmp(1, "mdl.b.", gnt_b, arvalid_b, araddr_b, rv_b, rd_b, err_b, rready_b);
            if (rst_n) begin
                model_step(0);
                model_step(1);
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b1;
        nxt();
    endtask

    logic [31:0] stream_exp [6] = '{32'h100002b7, 32'h0ff00313, 32'h0062a223,
                                    32'h0042a383, 32'h0000006f, 32'h00000013};

    initial begin
        int ngnt;
        rst_n   = 1'b0;
        req     = 1'b0;
        addr    = 32'h0;
        arready = 1'b1;

        nxt();
        nxt();
        #3;
        chk("rst.arvalid", 32'(arvalid_a), 32'h0);
        chk("rst.araddr",  araddr_a,       32'h0);
        chk("rst.rvalid",  32'(rv_a),      32'h0);
        chk("rst.rdata",   rd_a,           32'h0);
        chk("rst.err",     32'(err_a),     32'h0);
        chk("rst.gnt",     32'(gnt_a),     32'h0);
        nxt();
        rst_n = 1'b1;
        nxt();
        nxt();

        // Single fetch: grant, AR, R, OBI response
        req = 1'b1; addr = 32'h8;
        #3 chk("single.gnt", 32'(gnt_a), 32'h1);
        nxt();
        req = 1'b0; addr = 32'h0;
        #3;
        chk("single.arvalid", 32'(arvalid_a), 32'h1);
        chk("single.araddr",  araddr_a,       32'h8);
        nxt();
        #3 chk("single.rv_c2", 32'(rv_a), 32'h0);
        nxt();
        #3;
        chk("single.rv_c3", 32'(rv_a), 32'h1);
        chk("single.rdata", rd_a,       32'h0062a223);
        nxt();
        #3;
        chk("single.rv_c4",  32'(rv_a), 32'h0);
        chk("single.rdhold", rd_a,       32'h0062a223);
        nxt();

        // Streaming six ROM words back to back
        for (int k = 0; k < 10; k++) begin
            if (k < 6) begin
                req  = 1'b1;
                addr = 32'(4 * k);
            end else begin
                req = 1'b0;
            end
            #3;
            if (k < 6) chk($sformatf("stream.gnt%0d", k), 32'(gnt_a), 32'h1);
            if (k >= 3 && k < 9) begin
                chk($sformatf("stream.rv%0d", k), 32'(rv_a), 32'h1);
                chk($sformatf("stream.rd%0d", k), rd_a, stream_exp[k-3]);
            end
            if (k == 9) chk("stream.rv_end", 32'(rv_a), 32'h0);
            nxt();
        end

        // Credit limit on the 2-credit instance with a slow target
        do_reset();
        tgt_sel = 1'b1;
        tgt_lat = 10;
        ngnt    = 0;
        for (int k = 0; k < 27; k++) begin
            req  = (k < 14);
            addr = 32'h100 + 32'(4 * k);
            #3;
            if (k < 12) ngnt += int'(gnt_b);
            if (k >= 2 && k <= 11) chk($sformatf("credit.gnt%0d", k), 32'(gnt_b), 32'h0);
            if (k == 11) chk("credit.ngrants", 32'(ngnt), 32'h2);
            if (k == 12) begin
                chk("credit.rv12",  32'(rv_b),  32'h1);
                chk("credit.rd12",  rd_b,       32'hc0de_0100);
                chk("credit.gnt12", 32'(gnt_b), 32'h1);
            end
            nxt();
        end
        tgt_sel = 1'b0;
        tgt_lat = 1;
        do_reset();

        // AR backpressure: slot holds while arready is low
        req = 1'b1; addr = 32'h13; arready = 1'b1;
        #3 chk("bp.gnt0", 32'(gnt_a), 32'h1);
        nxt();
        for (int k = 1; k <= 4; k++) begin
            arready = 1'b0;
            req     = 1'b1;
            addr    = 32'h20;
            #3;
            chk($sformatf("bp.arvalid%0d", k), 32'(arvalid_a), 32'h1);
            chk($sformatf("bp.araddr%0d", k),  araddr_a,       32'h10);
            chk($sformatf("bp.gnt%0d", k),     32'(gnt_a),     32'h0);
            nxt();
        end
        arready = 1'b1;
        req     = 1'b0;
        #3;
        chk("bp.arvalid5", 32'(arvalid_a), 32'h1);
        chk("bp.araddr5",  araddr_a,       32'h10);
        nxt();
        #3;
        chk("bp.arvalid6", 32'(arvalid_a), 32'h0);
        chk("bp.araddr6",  araddr_a,       32'h10);
        nxt();
        #3;
        chk("bp.rv7", 32'(rv_a), 32'h1);
        chk("bp.rd7", rd_a,       32'h0000006f);
        nxt();
        nxt();

        // Unexpected response with no credits in use
        force_beat = 1'b1;
        force_data = 32'hbad0_0bad;
        #3 chk("unexp.err0", 32'(err_a), 32'h0);
        nxt();
        force_beat = 1'b0;
        #3;
        chk("unexp.rv1",   32'(rv_a),  32'h0);
        chk("unexp.rd1",   rd_a,       32'h0000006f);
        chk("unexp.err1",  32'(err_a), 32'h1);
        for (int k = 2; k < 5; k++) begin
            nxt();
            #3 chk($sformatf("unexp.err%0d", k), 32'(err_a), 32'h1);
        end
        nxt();

        // Reset with two fetches in flight and AR valid
        tgt_lat = 20;
        req = 1'b1; addr = 32'h44;
        #3 chk("rmid.gnt0", 32'(gnt_a), 32'h1);
        nxt();
        addr = 32'h48;
        #3 chk("rmid.gnt1", 32'(gnt_a), 32'h1);
        nxt();
        req = 1'b0;
        #3;
        chk("rmid.arvalid", 32'(arvalid_a), 32'h1);
        chk("rmid.araddr",  araddr_a,       32'h48);
        rst_n = 1'b0;
        #1;
        chk("rmid.rst_arvalid", 32'(arvalid_a), 32'h0);
        chk("rmid.rst_araddr",  araddr_a,       32'h0);
        chk("rmid.rst_rvalid",  32'(rv_a),      32'h0);
        chk("rmid.rst_rdata",   rd_a,           32'h0);
        chk("rmid.rst_err",     32'(err_a),     32'h0);
        chk("rmid.rst_gnt",     32'(gnt_a),     32'h0);
        nxt();
        nxt();
        tgt_lat = 1;
        rst_n   = 1'b1;
        req     = 1'b1;
        addr    = 32'h8;
        #3 chk("rmid.gnt_after", 32'(gnt_a), 32'h1);
        nxt();
        req = 1'b0;
        nxt();
        nxt();
        #3;
        chk("rmid.rv_after", 32'(rv_a), 32'h1);
        chk("rmid.rd_after", rd_a,       32'h0062a223);
        nxt();
        nxt();
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
